pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush.
//  Successor to fixed EX->MEM latches; one instance per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Adds back-pressure (stall) and bubble insertion (flush) without a combinational ready path.
//  Payload is split: CTRL (zeroed when invalid/flushed) and DATA (held, never cleared except by reset).
// PARAMETERS
//  CTRL_W  4   width of control payload (RegWrite, ResultSrc, MemWrite, ...); must be >=1
//  DATA_W  101 width of datapath payload (e.g. ALUResult+WriteData+Rd+PCPlus4); must be >=1
//  CNT_W   16  width of perf counters (only with PIPE_STAGE_REG_PERF_EN)
// PORTS
//  CLK        in   1       clock, rising edge
//  RST        in   1       asynchronous active-low reset
//  FLUSH      in   1       synchronous flush: kill all held entries
//  in_valid   in   1       upstream entry valid
//  in_ready   out  1       stage can accept; registered, = !skid_valid
//  in_ctrl    in   CTRL_W  upstream control payload
//  in_data    in   DATA_W  upstream datapath payload
//  out_valid  out  1       registered: main slot holds a valid entry
//  out_ready  in   1       downstream accepts (0 = stall)
//  out_ctrl   out  CTRL_W  main-slot control; all-zero whenever out_valid=0
//  out_data   out  DATA_W  main-slot data; holds last value when out_valid=0
//  stall_cnt  out  CNT_W   [PERF only] cycles with out_valid && !out_ready
//  flush_cnt  out  CNT_W   [PERF only] cycles with FLUSH=1 and >=1 valid entry killed
// BEHAVIOUR
//  Reset (RST=0, async): state EMPTY; out_valid=0, in_ready=1, out_ctrl=0, out_data=0, skid=0, counters=0.
//  Transfer in = in_valid&&in_ready; transfer out = out_valid&&out_ready; all updates on CLK rise.
//  FSM (state from main/skid valid bits): EMPTY=00, ONE=01, FULL=11 (skid valid only if main valid).
//   EMPTY: in xfer -> main<=in, ONE.  else stay.
//   ONE:   in xfer && out_ready -> main<=in, ONE (pass-through, 1/cycle);
//          in xfer && !out_ready -> skid<=in, FULL; !in_valid && out_ready -> EMPTY.
//   FULL:  in_ready=0; out_ready -> main<=skid, skid cleared, ONE; else hold.
//  Latency: 1 cycle in->out when EMPTY or ONE-with-drain; throughput 1 entry/cycle sustained.
//  Order preserved: skid entry always presented after main entry.
//  Stall: out_ready=0 holds out_* stable (ctrl and data) until accepted.
//  FLUSH=1: next edge -> EMPTY, out_valid=0, out_ctrl=0, in_ready=1; in payload that cycle dropped;
//   FLUSH overrides any simultaneous in/out transfer; out_data not cleared (don't-care).
//  Reset mid-transfer: all entries lost, outputs to reset values immediately (async).
//  in_ctrl/in_data ignored when in_valid=0 or in_ready=0; no combinational in->out or out_ready->in_ready path.
// CONFIGURATION
//  Macro PIPE_STAGE_REG_PERF_EN:
//   defined: stall_cnt/flush_cnt ports exist; increment per cycle on condition, saturate at all-ones,
//    cleared only by RST; FLUSH does not clear them.
//   undefined: ports and counters absent; handshake behaviour identical.
// STRUCTURE
//  Package pipe_pkg: state encoding constants (ST_EMPTY/ST_ONE/ST_FULL), default CTRL_W/DATA_W/CNT_W,
//   per-stage payload width constants for IF/ID, ID/EX, EX/MEM, MEM/WB.
//  Sub-module pipe_slot (CTRL_W, DATA_W): one storage entry with valid, load, clear (clear zeroes valid+ctrl);
//   instantiated twice (main, skid). FSM/mux and optional counters live in pipe_stage_reg.
// TESTING
//  T1 reset: RST=0 with in_valid=1 -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1; release -> still EMPTY.
//  T2 streaming: out_ready=1, in_valid=1 with data 1,2,3 on consecutive edges -> out_data 1,2,3 one cycle later,
//   out_valid=1 continuous, in_ready never 0.
//  T3 back-pressure: feed A,B with out_ready=0 -> after 2 edges in_ready=0, out_data=A held;
//   raise out_ready -> A then B, in_ready=1 one cycle after A accepted; no loss/duplication.
//  T4 flush while FULL with in_valid=1 (C) -> next cycle out_valid=0, out_ctrl=0, in_ready=1; C never appears.
//  T5 flush coincident with out transfer of A -> A counted consumed once, stage EMPTY after edge.
//  T6 [PERF, CNT_W=2] hold out_valid=1,out_ready=0 for 5 cycles -> stall_cnt=3 (saturated);
//   flush of EMPTY stage -> flush_cnt unchanged.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants for pipeline stage registers: slot-state encoding, default widths,
// and payload widths for each stage boundary of the core.
package pipe_pkg;

   // State is {skid_valid, main_valid}; 2'b10 cannot occur because skid only fills behind main
   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_ONE   = 2'b01;
   localparam logic [1:0] ST_FULL  = 2'b11;

   localparam int DEF_CTRL_W = 4;
   localparam int DEF_DATA_W = 101;
   localparam int DEF_CNT_W  = 16;

   // Instr + PC + PCPlus4
   localparam int IFID_CTRL_W  = 1;
   localparam int IFID_DATA_W  = 96;
   // RD1 + RD2 + PC + ImmExt + PCPlus4 + Rs1 + Rs2 + Rd
   localparam int IDEX_CTRL_W  = 10;
   localparam int IDEX_DATA_W  = 175;
   // ALUResult + WriteData + Rd + PCPlus4
   localparam int EXMEM_CTRL_W = 4;
   localparam int EXMEM_DATA_W = 101;
   // ALUResult + ReadData + Rd + PCPlus4
   localparam int MEMWB_CTRL_W = 3;
   localparam int MEMWB_DATA_W = 101;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry: valid bit, control payload (zeroed on clear) and data payload (held on clear).
// Latency: load visible one cycle later; clear has priority over load.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int CTRL_W = DEF_CTRL_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              load_i,
   input  logic              clear_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o
);

   logic              valid_q, valid_d;
   logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
   logic [DATA_W-1:0] data_q,  data_d;

   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      if (clear_i) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end else if (load_i) begin
         valid_d = 1'b1;
         ctrl_d  = ctrl_i;
         data_d  = data_i;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign ctrl_o  = ctrl_q;
   assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush; optional perf
// counters under PIPE_STAGE_REG_PERF_EN. 1-cycle latency, in_ready is registered (= !skid valid).
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W = DEF_CTRL_W,
   parameter int DATA_W = DEF_DATA_W
`ifdef PIPE_STAGE_REG_PERF_EN
   ,
   parameter int CNT_W  = DEF_CNT_W
`endif
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              FLUSH,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_REG_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   logic              main_ld, main_clr, main_from_skid;
   logic              skid_ld, skid_clr;
   logic              skid_vld;
   logic [CTRL_W-1:0] skid_ctrl, main_ctrl_in;
   logic [DATA_W-1:0] skid_data, main_data_in;
   logic [1:0]        state;

   assign state    = {skid_vld, out_valid};
   assign in_ready = ~skid_vld;

   always_comb begin
      main_ld        = 1'b0;
      main_clr       = 1'b0;
      main_from_skid = 1'b0;
      skid_ld        = 1'b0;
      skid_clr       = 1'b0;
      if (FLUSH) begin
         main_clr = 1'b1;
         skid_clr = 1'b1;
      end else begin
         case (state)
            ST_EMPTY: main_ld = in_valid;
            ST_ONE: begin
               if (in_valid) begin
                  main_ld = out_ready;
                  skid_ld = ~out_ready;
               end else begin
                  main_clr = out_ready;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so the upstream payload is ignored
               main_ld        = out_ready;
               main_from_skid = out_ready;
               skid_clr       = out_ready;
            end
            default: begin
               main_clr = 1'b1;
               skid_clr = 1'b1;
            end
         endcase
      end
   end

   assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
   assign main_data_in = main_from_skid ? skid_data : in_data;

   pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .CLK     (CLK),
      .RST     (RST),
      .load_i  (main_ld),
      .clear_i (main_clr),
      .ctrl_i  (main_ctrl_in),
      .data_i  (main_data_in),
      .valid_o (out_valid),
      .ctrl_o  (out_ctrl),
      .data_o  (out_data)
   );

   pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .CLK     (CLK),
      .RST     (RST),
      .load_i  (skid_ld),
      .clear_i (skid_clr),
      .ctrl_i  (in_ctrl),
      .data_i  (in_data),
      .valid_o (skid_vld),
      .ctrl_o  (skid_ctrl),
      .data_o  (skid_data)
   );

`ifdef PIPE_STAGE_REG_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   // Saturating counters; only reset clears them
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (out_valid && !out_ready && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (FLUSH && (out_valid || skid_vld) && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule
